// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;

    localparam int SERSUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_full_sub.sv
// rtl/serial_sub_full_sub.sv - single-bit full subtractor cell (a - b - bi)
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit and borrow-out of one bit position
    always_comb begin
        d  = a ^ b ^ bi;
        bo = (~a & b) | (~(a ^ b) & bi);
    end

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor with valid/ready handshakes; SERSUB_OVF_EN adds signed overflow output
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
`ifdef SERSUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             bout_r;
    logic             diff_bit;
    logic             bo_bit;
`ifdef SERSUB_OVF_EN
    logic             ovf_r;
`endif

    // The one arithmetic cell, fed from the operand LSBs and the borrow flop
    full_sub u_full_sub (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (borrow),
        .d  (diff_bit),
        .bo (bo_bit)
    );

    // Handshake flags decode state only; in_ready is also held low during reset
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        d         = d_sr;
        bout      = bout_r;
`ifdef SERSUB_OVF_EN
        ovf       = ovf_r;
`endif
    end

    // Control FSM and serial datapath: capture, shift one bit per cycle, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            bout_r <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    d_sr   <= {diff_bit, d_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= bo_bit;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        // Borrow flop still holds the borrow into the MSB here
                        bout_r <= bo_bit;
`ifdef SERSUB_OVF_EN
                        ovf_r  <= borrow ^ bo_bit;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
`ifdef SERSUB_OVF_EN
                        ovf_r <= 1'b0;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed self-checking bench for serial_sub (WIDTH=8)
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       bout;
`ifdef SERSUB_OVF_EN
    logic       ovf;
`endif

    int n_cmp;
    int n_err;

    serial_sub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
`ifdef SERSUB_OVF_EN
        .bout      (bout),
        .ovf       (ovf)
`else
        .bout      (bout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold>0 keeps out_ready low that many cycles in DONE
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tbin, input logic [7:0] ed, input logic eb,
                         input logic eo, input int hold);
        int lat;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta; b = ta; bin = ~tbin;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_d"}, 32'(d), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERSUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unused ovf expectation");
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            a = 8'hFF; b = 8'h00;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_d"}, 32'(d), 32'(ed));
            check({tag, "_hold_bout"}, 32'(bout), 32'(eb));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        do_op("sub35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 0);
        do_op("sub00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        do_op("sub80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
        do_op("sub10_0f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0);
        do_op("sub7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
        do_op("bp_c3_3c", 8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0, 1'b0, 5);

        // Reset in the middle of RUN: after bits 0..3 have been processed
        @(negedge clk);
        a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_d", 32'(d), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_rel_ready", 32'(in_ready), 32'd1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("midrst_no_valid", 32'(seen), 32'd0);
        end
        do_op("sub05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
